lock_ctrl: RTL and testbench

Sequencing controller for the digital lock. It collects a four-digit keypad code, compares it against a stored code, and opens the lock on a match. It counts failed attempts in the 3-bit attempt count `ua`, and enters a timed lockout once `ua` exceeds the permitted failure count. It sits between the keypad scanner and the lock actuator/alarm drivers, and owns the attempt-count register that feeds the attempt comparator.

---
 rtl/lock_ctrl_if.sv | 22 ++
 rtl/lock_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lock_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_ctrl_if.sv
// Keypad/actuator bundle for lock_ctrl: keypad strobes in, actuator and status out.
interface lock_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       clear;
  logic       lock_cmd;
  logic       unlock;
  logic       lockout;
  logic       err;
  logic [2:0] ua;
  logic [2:0] digits;

  modport master (
    output key_valid, key_digit, clear, lock_cmd,
    input  unlock, lockout, err, ua, digits
  );

  modport slave (
    input  key_valid, key_digit, clear, lock_cmd,
    output unlock, lockout, err, ua, digits
  );
endinterface

// File: rtl/lock_ctrl.sv
// Digital lock sequencer: four-digit entry, code compare, timed open and
// failed-attempt lockout. Every output comes straight from a register.
module lock_ctrl #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  lock_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  // Timer counts completed cycles in a state, so the exit edge is at LAST.
  localparam logic [15:0] OPEN_LAST = 16'(OPEN_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  FAIL_LIM  = 3'(MAX_FAIL);

  logic [2:0]  state_q,   state_d;
  logic [15:0] timer_q,   timer_d;
  logic [15:0] entry_q,   entry_d;
  logic        unlock_q,  unlock_d;
  logic        lockout_q, lockout_d;
  logic        err_q,     err_d;
  logic [2:0]  ua_q,      ua_d;
  logic [2:0]  digits_q,  digits_d;

  logic [2:0]  ua_inc;
  logic [15:0] shift_in;
  logic        timeout_hit;
  logic        mismatch;
  logic        fail;

  always_comb begin
    ua_inc      = (ua_q == 3'd7) ? 3'd7 : ua_q + 3'd1;
    shift_in    = {entry_q[11:0], bus.key_digit};
    timeout_hit = (state_q == S_ENTRY) && !bus.clear && !bus.key_valid &&
                  (timer_q == TO_LAST);
    mismatch    = (state_q == S_CHECK) && (entry_q != CODE);
    fail        = timeout_hit || mismatch;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    entry_d   = entry_q;
    unlock_d  = unlock_q;
    lockout_d = lockout_q;
    err_d     = 1'b0;
    ua_d      = ua_q;
    digits_d  = digits_q;

    case (state_q)
      S_IDLE: begin
        if (bus.key_valid) begin
          entry_d  = shift_in;
          digits_d = 3'd1;
          timer_d  = '0;
          state_d  = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (bus.clear) begin
          digits_d = 3'd0;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else if (bus.key_valid) begin
          entry_d  = shift_in;
          digits_d = digits_q + 3'd1;
          timer_d  = '0;
          if (digits_q == 3'd3) state_d = S_CHECK;
        end else if (!timeout_hit) begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_CHECK: begin
        digits_d = 3'd0;
        timer_d  = '0;
        if (!mismatch) begin
          ua_d     = 3'd0;
          unlock_d = 1'b1;
          state_d  = S_OPEN;
        end
      end

      S_OPEN: begin
        if (bus.lock_cmd || timer_q == OPEN_LAST) begin
          unlock_d = 1'b0;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          lockout_d = 1'b0;
          ua_d      = 3'd0;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      default: begin
        unlock_d  = 1'b0;
        lockout_d = 1'b0;
        digits_d  = 3'd0;
        timer_d   = '0;
        state_d   = S_IDLE;
      end
    endcase

    // Entry timeout and code mismatch share one failure path.
    if (fail) begin
      ua_d     = ua_inc;
      err_d    = 1'b1;
      digits_d = 3'd0;
      timer_d  = '0;
      if (ua_inc > FAIL_LIM) begin
        lockout_d = 1'b1;
        state_d   = S_LOCKOUT;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      entry_q   <= '0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      err_q     <= 1'b0;
      ua_q      <= 3'd0;
      digits_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      entry_q   <= entry_d;
      unlock_q  <= unlock_d;
      lockout_q <= lockout_d;
      err_q     <= err_d;
      ua_q      <= ua_d;
      digits_q  <= digits_d;
    end
  end

  assign bus.unlock  = unlock_q;
  assign bus.lockout = lockout_q;
  assign bus.err     = err_q;
  assign bus.ua      = ua_q;
  assign bus.digits  = digits_q;

  a_open_xor_lock: assert property (@(posedge clk) disable iff (!rst_n)
    !(unlock_q && lockout_q));

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed vector table, multi-cycle corner sequences,
// and random traffic against an event-level reference model.
module tb_lock_ctrl;
  localparam logic [15:0] CODE = 16'h1234;
  localparam int MAX_FAIL = 3;
  localparam int OPEN_C   = 8;
  localparam int LOCK_C   = 16;
  localparam int TO_C     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lock_ctrl_if bus();

  lock_ctrl #(
    .CODE(CODE), .MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(OPEN_C),
    .LOCKOUT_CYCLES(LOCK_C), .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: digits held in a queue, open/lockout as remaining-cycle budgets.
  int  m_q[$];
  bit  m_chk;
  int  m_open, m_lock, m_idle, m_fails;
  bit  m_err;

  task automatic m_reset();
    m_q.delete();
    m_chk = 0; m_open = 0; m_lock = 0; m_idle = 0; m_fails = 0; m_err = 0;
  endtask

  task automatic m_fail();
    m_fails = (m_fails < 7) ? m_fails + 1 : 7;
    m_err = 1;
    m_q.delete();
    if (m_fails > MAX_FAIL) m_lock = LOCK_C;
  endtask

  task automatic m_step(bit kv, int d, bit clr, bit lc);
    m_err = 0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_open > 0) begin
      if (lc || m_open == 1) m_open = 0;
      else m_open--;
    end else if (m_chk) begin
      int code;
      code = 0;
      m_chk = 0;
      foreach (m_q[i]) code = code * 16 + m_q[i];
      m_q.delete();
      if (code == int'(CODE)) begin
        m_open = OPEN_C;
        m_fails = 0;
      end else m_fail();
    end else if (m_q.size() == 0) begin
      if (kv) begin m_q.push_back(d); m_idle = 0; end
    end else if (clr) begin
      m_q.delete();
    end else if (kv) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == 4) m_chk = 1;
    end else begin
      m_idle++;
      if (m_idle == TO_C) m_fail();
    end
  endtask

  task automatic drive(bit kv, logic [3:0] d, bit clr, bit lc);
    @(negedge clk);
    bus.key_valid = kv; bus.key_digit = d; bus.clear = clr; bus.lock_cmd = lc;
    @(posedge clk);
    #1;
    m_step(kv, int'(d), clr, lc);
  endtask

  task automatic step(bit kv, logic [3:0] d, bit clr, bit lc);
    drive(kv, d, clr, lc);
    chk("unlock",  32'(bus.unlock),  32'(m_open > 0));
    chk("lockout", 32'(bus.lockout), 32'(m_lock > 0));
    chk("err",     32'(bus.err),     32'(m_err));
    chk("ua",      32'(bus.ua),      32'(m_fails));
    chk("digits",  32'(bus.digits),  32'(m_q.size()));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0);
  endtask

  task automatic enter(logic [15:0] c);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] s;
      s = c >> (12 - 4 * i);
      step(1, s[3:0], 0, 0);
    end
  endtask

  typedef struct {
    bit kv; logic [3:0] d; bit clr; bit lc;
    bit u; bit lo; bit e; logic [2:0] ua; logic [2:0] dg;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit kv, logic [3:0] d, bit clr, bit lc,
                              bit u, bit lo, bit e, logic [2:0] ua, logic [2:0] dg);
    vec_t v;
    v.kv = kv; v.d = d; v.clr = clr; v.lc = lc;
    v.u = u; v.lo = lo; v.e = e; v.ua = ua; v.dg = dg;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lo_cnt, u_seen, err_at;
    bus.key_valid = 0; bus.key_digit = 0; bus.clear = 0; bus.lock_cmd = 0;
    m_reset();

    // Correct code, 8-cycle open, then a wrong code.
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 2));
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 3));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 4));
    for (int i = 0; i < 8; i++) tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 2));
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 3));
    tv.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 4));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    // clear beats a same-cycle key; lock_cmd in IDLE does nothing.
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 2));
    tv.push_back(mk(1, 3, 1, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
    // Open, then relock on the third open cycle.
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 2));
    tv.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 3));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 0, 1, 4));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    #12;
    chk("rst_unlock",  32'(bus.unlock),  0);
    chk("rst_lockout", 32'(bus.lockout), 0);
    chk("rst_err",     32'(bus.err),     0);
    chk("rst_ua",      32'(bus.ua),      0);
    chk("rst_digits",  32'(bus.digits),  0);
    @(negedge clk);
    rst_n = 1;

    foreach (tv[i]) begin
      drive(tv[i].kv, tv[i].d, tv[i].clr, tv[i].lc);
      chk("tv_unlock",  32'(bus.unlock),  32'(tv[i].u));
      chk("tv_lockout", 32'(bus.lockout), 32'(tv[i].lo));
      chk("tv_err",     32'(bus.err),     32'(tv[i].e));
      chk("tv_ua",      32'(bus.ua),      32'(tv[i].ua));
      chk("tv_digits",  32'(bus.digits),  32'(tv[i].dg));
    end

    // Four wrong codes walk ua to 4 and trip a 16-cycle lockout.
    for (int a = 1; a <= 4; a++) begin
      enter(16'h5555);
      idle(1);
      chk("fail_ua", 32'(bus.ua), 32'(a));
    end
    chk("lockout_rise", 32'(bus.lockout), 1);
    lo_cnt = 1; u_seen = 0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] s;
      s = CODE >> (12 - 4 * (i % 4));
      step(1, s[3:0], 0, 0);
      lo_cnt += int'(bus.lockout);
      u_seen += int'(bus.unlock);
    end
    chk("lockout_len", 32'(lo_cnt), 16);
    chk("lockout_no_unlock", 32'(u_seen), 0);
    chk("lockout_exit_ua", 32'(bus.ua), 0);
    enter(CODE);
    idle(1);
    chk("post_lockout_unlock", 32'(bus.unlock), 1);
    idle(8);

    // Timeout: one key, then the failure lands 32 edges later.
    step(1, 4'h1, 0, 0);
    err_at = 0;
    for (int i = 1; i <= 34; i++) begin
      step(0, 4'h0, 0, 0);
      if (bus.err && err_at == 0) err_at = i;
    end
    chk("timeout_edge", 32'(err_at), 32'(TO_C));
    chk("timeout_ua", 32'(bus.ua), 1);

    // Async reset while locked out with ua=4.
    for (int a = 0; a < 3; a++) begin enter(16'h9876); idle(1); end
    idle(2);
    chk("pre_rst_lockout", 32'(bus.lockout), 1);
    chk("pre_rst_ua", 32'(bus.ua), 4);
    #3;
    rst_n = 0;
    #1;
    chk("arst_lockout", 32'(bus.lockout), 0);
    chk("arst_ua",      32'(bus.ua),      0);
    chk("arst_digits",  32'(bus.digits),  0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    enter(CODE);
    idle(1);
    chk("post_rst_unlock", 32'(bus.unlock), 1);
    idle(8);

    // Random traffic, biased toward the right code; quiet segments hit timeouts.
    for (int seg = 0; seg < 30; seg++) begin
      int kvp;
      kvp = (seg % 5 == 4) ? 2 : 35;
      for (int i = 0; i < 100; i++) begin
        bit kv, clr, lc;
        logic [3:0] d;
        logic [15:0] s;
        kv  = ($urandom_range(99) < kvp);
        clr = ($urandom_range(99) < 3);
        lc  = ($urandom_range(99) < 6);
        s   = CODE >> (12 - 4 * (m_q.size() % 4));
        d   = ($urandom_range(99) < 75) ? s[3:0] : 4'($urandom_range(15));
        step(kv, d, clr, lc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
